mem_arbiter: RTL and testbench

Two-port memory arbiter and sequencer placed between the multicycle MIPS core, a second bus master (program loader / DMA), and the single shared memory port. It accepts one outstanding access at a time, chooses between requesters round-robin, drives a request/acknowledge handshake to memory that tolerates wait states, and returns a one-cycle acknowledge with registered read data to the winner. A watchdog aborts accesses that memory never acknowledges.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and memory sequencer for the core and loader ports.
// One access is in flight at a time; a watchdog aborts accesses that memory never acknowledges.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_adr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic {CORE = 1'b0, LOADER = 1'b1} port_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  port_t       owner_q, owner_d, last_q, last_d, winner;
  logic [7:0]  wdog_q, wdog_d;
  logic        m_req_d, m_we_d, c_ack_d, d_ack_d, terr_d, finish;
  logic [31:0] m_adr_d, m_wdata_d, c_rdata_d, d_rdata_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (a latch).
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    m_req_d   = m_req;
    m_we_d    = m_we;
    m_adr_d   = m_adr;
    m_wdata_d = m_wdata;
    c_rdata_d = c_rdata;
    d_rdata_d = d_rdata;
    c_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    terr_d    = timeout_err;
    finish    = 1'b0;

    // On a tie the port that did not win last time goes first.
    winner = CORE;
    if (c_req && d_req) winner = (last_q == CORE) ? LOADER : CORE;
    else if (d_req)     winner = LOADER;

    unique case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          state_d   = SERVE;
          owner_d   = winner;
          last_d    = winner;
          wdog_d    = 8'd0;
          m_req_d   = 1'b1;
          m_we_d    = (winner == CORE) ? c_we    : d_we;
          m_adr_d   = (winner == CORE) ? c_adr   : d_adr;
          m_wdata_d = (winner == CORE) ? c_wdata : d_wdata;
        end
      end
      SERVE: begin
        if (m_ack) begin
          finish = 1'b1;
          if (!m_we) begin
            if (owner_q == CORE) c_rdata_d = m_rdata;
            else                 d_rdata_d = m_rdata;
          end
        end else if (wdog_q == TMO) begin
          finish = 1'b1;
          terr_d = 1'b1;
          if (!m_we) begin
            if (owner_q == CORE) c_rdata_d = 32'h0;
            else                 d_rdata_d = 32'h0;
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
        if (finish) begin
          m_req_d = 1'b0;
          state_d = DONE;
          c_ack_d = (owner_q == CORE);
          d_ack_d = (owner_q == LOADER);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= CORE;
      last_q      <= LOADER;
      wdog_q      <= 8'd0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_adr       <= 32'h0;
      m_wdata     <= 32'h0;
      c_rdata     <= 32'h0;
      d_rdata     <= 32'h0;
      c_ack       <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wdog_q      <= wdog_d;
      m_req       <= m_req_d;
      m_we        <= m_we_d;
      m_adr       <= m_adr_d;
      m_wdata     <= m_wdata_d;
      c_rdata     <= c_rdata_d;
      d_rdata     <= d_rdata_d;
      c_ack       <= c_ack_d;
      d_ack       <= d_ack_d;
      timeout_err <= terr_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two requester drivers, a wait-state memory model,
// an arbitration predictor and per-port expected-result queues.
module tb_mem_arbiter;

  localparam int TMO = 4;
  localparam bit PORT_C = 1'b0;
  localparam bit PORT_D = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } op_t;

  logic        clk, reset;
  logic        c_req, c_we, c_ack, d_req, d_we, d_ack;
  logic [31:0] c_adr, c_wdata, c_rdata, d_adr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack, busy, timeout_err;
  logic [31:0] m_adr, m_wdata, m_rdata;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  op_t         c_ops[$], d_ops[$], c_exp[$], d_exp[$];
  op_t         cur_c, cur_d, act_op;
  logic [31:0] mem_model [logic [31:0]];
  int          mem_wait;
  bit          mem_never;
  int          cyc, grant_cyc;
  int          n_vec, n_err;
  bit          t_last, cur_owner, pred_valid, in_serve;
  logic [31:0] exp_c_rd, exp_d_rd;
  logic        exp_terr;
  bit          ack_log[$];
  int          ack_cyc_log[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Core requester: holds req until ack, then presents the next queued op; noise while idle.
  initial begin
    c_req = 1'b0; c_we = 1'b0; c_adr = 32'h0; c_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (c_req && c_ack) c_req = 1'b0;
      if (!c_req && c_ops.size() > 0) begin
        cur_c = c_ops.pop_front();
        cur_c.rdata = mem_never ? 32'h0 : mem_rd(cur_c.adr);
        c_exp.push_back(cur_c);
        c_req = 1'b1; c_we = cur_c.we; c_adr = cur_c.adr; c_wdata = cur_c.wdata;
      end else if (!c_req) begin
        c_we = 1'($urandom); c_adr = $urandom; c_wdata = $urandom;
      end
    end
  end

  initial begin
    d_req = 1'b0; d_we = 1'b0; d_adr = 32'h0; d_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (d_req && d_ack) d_req = 1'b0;
      if (!d_req && d_ops.size() > 0) begin
        cur_d = d_ops.pop_front();
        cur_d.rdata = mem_never ? 32'h0 : mem_rd(cur_d.adr);
        d_exp.push_back(cur_d);
        d_req = 1'b1; d_we = cur_d.we; d_adr = cur_d.adr; d_wdata = cur_d.wdata;
      end else if (!d_req) begin
        d_we = 1'($urandom); d_adr = $urandom; d_wdata = $urandom;
      end
    end
  end

  // Memory: acks in SERVE cycle mem_wait+1, garbage on m_rdata except for read acks.
  initial begin
    int cnt;
    cnt = 0; m_ack = 1'b0; m_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (!reset || m_req !== 1'b1) begin
        cnt = 0; m_ack = 1'b0; m_rdata = 32'hDEAD_BEEF;
      end else begin
        cnt++;
        if (!mem_never && cnt == mem_wait + 1) begin
          m_ack = 1'b1;
          if (m_we) mem_model[m_adr] = m_wdata;
          m_rdata = m_we ? 32'hBAD0_0BAD : mem_rd(m_adr);
        end else begin
          m_ack = 1'b0; m_rdata = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor: predicts the grant, checks the memory-side command and scores every ack.
  initial begin
    op_t        e;
    logic [1:0] want;
    forever begin
      @(negedge clk); #1;
      if (!reset) continue;
      if (pred_valid) begin
        pred_valid = 1'b0;
        in_serve   = 1'b1;
        check("grant_m_req", 32'(m_req), 32'd1);
        check("grant_busy", 32'(busy), 32'd1);
      end
      if (in_serve && m_req === 1'b1) begin
        check("m_we", 32'(m_we), 32'(act_op.we));
        check("m_adr", m_adr, act_op.adr);
        check("m_wdata", m_wdata, act_op.wdata);
      end
      if (c_ack === 1'b1 || d_ack === 1'b1) begin
        in_serve = 1'b0;
        want = (cur_owner == PORT_C) ? 2'b10 : 2'b01;
        check("ack_port", {30'h0, c_ack, d_ack}, {30'h0, want});
        check("ack_latency", 32'(cyc - grant_cyc), mem_never ? 32'(TMO + 2) : 32'(mem_wait + 2));
        check("done_busy", 32'(busy), 32'd1);
        if (mem_never) exp_terr = 1'b1;
        check("timeout_err", 32'(timeout_err), 32'(exp_terr));
        ack_log.push_back(c_ack ? PORT_C : PORT_D);
        ack_cyc_log.push_back(cyc);
        if (c_ack) begin
          if (c_exp.size() == 0) check("c_ack_spurious", 32'(c_ack), 32'd0);
          else begin
            e = c_exp.pop_front();
            if (!e.we) exp_c_rd = e.rdata;
            check("c_rdata", c_rdata, exp_c_rd);
            check("d_rdata_kept", d_rdata, exp_d_rd);
          end
        end
        if (d_ack) begin
          if (d_exp.size() == 0) check("d_ack_spurious", 32'(d_ack), 32'd0);
          else begin
            e = d_exp.pop_front();
            if (!e.we) exp_d_rd = e.rdata;
            check("d_rdata", d_rdata, exp_d_rd);
            check("c_rdata_kept", c_rdata, exp_c_rd);
          end
        end
      end else if (busy === 1'b0 && (c_req || d_req)) begin
        if (c_req && d_req) cur_owner = (t_last == PORT_C) ? PORT_D : PORT_C;
        else                cur_owner = c_req ? PORT_C : PORT_D;
        t_last     = cur_owner;
        act_op     = (cur_owner == PORT_C) ? cur_c : cur_d;
        grant_cyc  = cyc;
        pred_valid = 1'b1;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk); #3;
    reset = 1'b0;
    #1;
    check("rst_ctl", {26'h0, m_req, m_we, c_ack, d_ack, busy, timeout_err}, 32'h0);
    check("rst_m_adr", m_adr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_c_rdata", c_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    exp_c_rd = 32'h0; exp_d_rd = 32'h0; exp_terr = 1'b0;
    t_last = PORT_D; pred_valid = 1'b0; in_serve = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((c_ops.size() + d_ops.size() + c_exp.size() + d_exp.size() != 0 || c_req || d_req) && n < 400) begin
      @(negedge clk); #2;
      n++;
    end
    check("drain_pending", 32'(c_ops.size() + d_ops.size() + c_exp.size() + d_exp.size()), 32'd0);
    @(negedge clk); #2;
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; mem_wait = 0; mem_never = 1'b0;
    exp_c_rd = 32'h0; exp_d_rd = 32'h0; exp_terr = 1'b0;
    t_last = PORT_D; pred_valid = 1'b0; in_serve = 1'b0; cur_owner = PORT_C; grant_cyc = 0;
    apply_reset();

    // Zero-wait core read.
    mem_model[32'h100] = 32'h1234_5678;
    c_ops.push_back('{we: 1'b0, adr: 32'h100, wdata: 32'h0, rdata: 32'h0});
    wait_idle();
    check("t1_c_rdata", c_rdata, 32'h1234_5678);

    // Loader write with three wait states, then read it back.
    mem_wait = 3;
    d_ops.push_back('{we: 1'b1, adr: 32'h40, wdata: 32'hCAFE_F00D, rdata: 32'h0});
    wait_idle();
    check("t2_mem_written", mem_rd(32'h40), 32'hCAFE_F00D);
    d_ops.push_back('{we: 1'b0, adr: 32'h40, wdata: 32'h0, rdata: 32'h0});
    wait_idle();
    check("t2_d_readback", d_rdata, 32'hCAFE_F00D);

    // Both ports request continuously from reset.
    apply_reset();
    mem_wait = 0;
    ack_log.delete(); ack_cyc_log.delete();
    for (int i = 0; i < 4; i++) begin
      c_ops.push_back('{we: 1'b0, adr: 32'h200 + 32'(i * 4), wdata: 32'h0, rdata: 32'h0});
      d_ops.push_back('{we: 1'(i % 2), adr: 32'h800 + 32'((i / 2) * 4), wdata: 32'hA000_0000 + 32'(i), rdata: 32'h0});
    end
    wait_idle();
    check("t3_ack_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < ack_log.size(); i++)
      check("t3_alternate", 32'(ack_log[i]), (i % 2 == 0) ? 32'(PORT_C) : 32'(PORT_D));
    for (int i = 1; i < ack_cyc_log.size(); i++)
      check("t3_ack_spacing", 32'(ack_cyc_log[i] - ack_cyc_log[i-1]), 32'd3);

    // Memory never acks: abort, zero read data, sticky error.
    mem_never = 1'b1;
    c_ops.push_back('{we: 1'b0, adr: 32'h300, wdata: 32'h0, rdata: 32'h0});
    wait_idle();
    check("t4_c_rdata_zero", c_rdata, 32'h0);
    mem_never = 1'b0;
    d_ops.push_back('{we: 1'b0, adr: 32'h304, wdata: 32'h0, rdata: 32'h0});
    c_ops.push_back('{we: 1'b1, adr: 32'h308, wdata: 32'h1357_9BDF, rdata: 32'h0});
    wait_idle();
    check("t4_terr_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of SERVE; both requests stay pending across it.
    mem_wait = 10;
    c_ops.push_back('{we: 1'b0, adr: 32'h500, wdata: 32'h0, rdata: 32'h0});
    d_ops.push_back('{we: 1'b0, adr: 32'h900, wdata: 32'h0, rdata: 32'h0});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (m_req === 1'b1) break;
    end
    check("t5_in_serve", 32'(m_req), 32'd1);
    // The in-flight count is already past the zero-wait slot, so no ack before the reset lands.
    mem_wait = 0;
    ack_log.delete(); ack_cyc_log.delete();
    apply_reset();
    wait_idle();
    check("t5_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check("t5_first_core", 32'(ack_log[0]), 32'(PORT_C));
      check("t5_then_loader", 32'(ack_log[1]), 32'(PORT_D));
    end
    check("t5_terr_cleared", 32'(timeout_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
